// File: rtl/bcd_serial_alu.sv
// Digit-serial BCD add/subtract unit: one single-digit BCD adder cell is reused
// over all operand digits, least significant first, with the carry held between cycles.
module bcd_serial_alu #(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                op,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] result,
    output logic                ovf,
    output logic                invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   result_q;
    logic           op_q;
    logic           carry;
    logic           ovf_q;
    logic           invalid_q;
    logic [CW-1:0]  cnt;

    logic           operands_ok;
    logic           last_digit;
    logic [3:0]     a_dig;
    logic [3:0]     b_dig;
    logic [4:0]     sum_bin;
    logic [3:0]     sum_dig;
    logic           cout;

    function automatic logic all_digits_bcd(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    assign operands_ok = all_digits_bcd(a) && all_digits_bcd(b);
    assign last_digit  = (cnt == CW'(DIGITS - 1));

    // Subtraction feeds the nine's complement of B; the +1 enters through the initial carry.
    always_comb begin
        a_dig   = a_sh[3:0];
        b_dig   = op_q ? (4'd9 - b_sh[3:0]) : b_sh[3:0];
        sum_bin = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry};
        cout    = (sum_bin > 5'd9);
        sum_dig = cout ? (sum_bin[3:0] + 4'd6) : sum_bin[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = operands_ok ? CALC : DONE;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operands shift right one digit per step so the cell always sees the current digit at [3:0].
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            result_q  <= '0;
            op_q      <= 1'b0;
            carry     <= 1'b0;
            ovf_q     <= 1'b0;
            invalid_q <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh      <= a;
                        b_sh      <= b;
                        op_q      <= op;
                        carry     <= op;
                        cnt       <= '0;
                        result_q  <= '0;
                        ovf_q     <= 1'b0;
                        invalid_q <= ~operands_ok;
                    end
                end
                CALC: begin
                    result_q[{cnt, 2'b00} +: 4] <= sum_dig;
                    carry <= cout;
                    cnt   <= cnt + 1'b1;
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    if (last_digit) begin
                        ovf_q <= op_q ? ~cout : cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result  = result_q;
    assign ovf     = ovf_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_alu.sv
// Scoreboard bench for bcd_serial_alu: expected responses come from a decimal
// arithmetic model and are checked by an independent monitor on each done pulse.
module tb_bcd_serial_alu;

    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;

    logic         clk;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         ovf;
    logic         invalid;

    typedef struct {
        logic [W-1:0] result;
        logic         ovf;
        logic         inv;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;
    int   cyc;
    logic prev_done;

    bcd_serial_alu #(.DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .ovf     (ovf),
        .invalid (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Decimal reference: operands converted to integers, result converted back to BCD.
    function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   xv, yv, pw, r;
        bit   bad;
        xv  = 0;
        yv  = 0;
        pw  = 1;
        bad = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) bad = 1;
            xv = xv * 10 + int'(x[4*i +: 4]);
            yv = yv * 10 + int'(y[4*i +: 4]);
            pw = pw * 10;
        end
        e.result = '0;
        e.ovf    = 1'b0;
        e.inv    = bad;
        e.cyc    = 0;
        if (!bad) begin
            if (o == 1'b0) begin
                r     = xv + yv;
                e.ovf = (r >= pw);
                r     = r % pw;
            end else begin
                r     = xv - yv;
                e.ovf = (r < 0);
                r     = (r + pw) % pw;
            end
            for (int i = 0; i < DIGITS; i++) begin
                e.result[4*i +: 4] = 4'(r % 10);
                r = r / 10;
            end
        end
        return e;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy !== 1'b0 || done !== 1'b0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_output("wait_idle", {31'b0, busy}, 32'h0);
    endtask

    task automatic push_expected(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e     = model(o, x, y);
        e.cyc = cyc + 1 + (e.inv ? 0 : DIGITS);
        sb.push_back(e);
    endtask

    task automatic apply_stimulus(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        wait_idle();
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        push_expected(o, x, y);
        e = model(o, x, y);
        @(negedge clk);
        start = 1'b0;
        op    = ~o;
        a     = W'($urandom);
        b     = W'($urandom);
        check_output("busy_after_accept", {31'b0, busy}, {31'b0, ~e.inv});
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (done) begin
                check_output("done_single_cycle", {31'b0, prev_done}, 32'h0);
                check_output("busy_at_done", {31'b0, busy}, 32'h0);
                if (sb.size() == 0) begin
                    check_output("unexpected_done", {31'b0, done}, 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_output("result", 32'(result), 32'(e.result));
                    check_output("ovf", {31'b0, ovf}, {31'b0, e.ovf});
                    check_output("invalid", {31'b0, invalid}, {31'b0, e.inv});
                    check_output("done_cycle", cyc, e.cyc);
                end
            end
            prev_done = done;
        end
    end

    initial begin
        int n;
        n_checks  = 0;
        n_fail    = 0;
        prev_done = 1'b0;
        rst       = 1'b1;
        start     = 1'b0;
        op        = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        check_output("reset_busy", {31'b0, busy}, 32'h0);
        check_output("reset_done", {31'b0, done}, 32'h0);
        check_output("reset_result", 32'(result), 32'h0);
        check_output("reset_ovf", {31'b0, ovf}, 32'h0);
        check_output("reset_invalid", {31'b0, invalid}, 32'h0);
        rst = 1'b0;

        apply_stimulus(1'b0, 8'h27, 8'h35);
        apply_stimulus(1'b0, 8'h99, 8'h01);
        apply_stimulus(1'b0, 8'h45, 8'h54);
        apply_stimulus(1'b0, 8'h3A, 8'h10);
        apply_stimulus(1'b1, 8'h52, 8'h17);
        apply_stimulus(1'b1, 8'h40, 8'h40);
        apply_stimulus(1'b1, 8'h05, 8'h12);

        // Abort an operation with reset in its second digit cycle; nothing is expected from it.
        wait_idle();
        op    = 1'b0;
        a     = 8'h88;
        b     = 8'h77;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("abort_busy", {31'b0, busy}, 32'h0);
        check_output("abort_done", {31'b0, done}, 32'h0);
        check_output("abort_result", 32'(result), 32'h0);
        check_output("abort_ovf", {31'b0, ovf}, 32'h0);
        check_output("abort_invalid", {31'b0, invalid}, 32'h0);
        repeat (4) @(negedge clk);

        // A second start during the digit cycles must be ignored.
        apply_stimulus(1'b0, 8'h27, 8'h35);
        op    = 1'b1;
        a     = 8'h11;
        b     = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Start held high: every return to idle accepts a new operation.
        wait_idle();
        op    = 1'b0;
        a     = 8'h11;
        b     = 8'h22;
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (busy == 1'b0 && done == 1'b0) push_expected(1'b0, 8'h11, 8'h22);
            @(negedge clk);
        end
        start = 1'b0;

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] x, y;
            for (int d = 0; d < DIGITS; d++) begin
                x[4*d +: 4] = 4'($urandom_range(9, 0));
                y[4*d +: 4] = 4'($urandom_range(9, 0));
            end
            if ($urandom_range(7, 0) == 0) x[4*$urandom_range(DIGITS-1, 0) +: 4] = 4'($urandom_range(15, 10));
            if ($urandom_range(7, 0) == 0) y[4*$urandom_range(DIGITS-1, 0) +: 4] = 4'($urandom_range(15, 10));
            apply_stimulus(1'($urandom_range(1, 0)), x, y);
        end

        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check_output("drain", sb.size(), 32'h0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
